// File: rtl/addsub_pipe.sv
// Two-stage valid/ready add/subtract pipeline with a count of consumed result beats.
// Optional macro ADDSUB_SAT_EN clamps a subtract that underflows (A < B) to X = 0.
module addsub_pipe #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   X,
  output logic                  borrow,
  output logic                  zero,
  output logic [CNT_WIDTH-1:0]  txn_count
);

  // Handshake: a beat moves across an interface on a rising edge where its
  // valid and ready are both 1; a producer holds its beat until that happens.
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH:0]   x_q, x_d;
  logic                  borrow_q, borrow_d;
  logic                  zero_q, zero_d;
  logic [CNT_WIDTH-1:0]  txn_count_q, txn_count_d;

  logic                  s2_adv;
  logic                  in_ready_int;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]   x_next;
  logic                  borrow_next;

  always_comb begin
    s2_adv       = !out_valid_q || out_ready;
    in_ready_int = !rst && (!s1_valid_q || s2_adv);

    sum         = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff        = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    borrow_next = s1_op_q && (s1_a_q < s1_b_q);
    x_next      = s1_op_q ? diff : sum;
`ifdef ADDSUB_SAT_EN
    if (borrow_next) begin
      x_next = '0;
    end
`endif

    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
    txn_count_d = txn_count_q;

    // Result fields only change when a new beat lands, so they stay stable under stall.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        x_d      = x_next;
        borrow_d = borrow_next;
        zero_d   = (x_next == '0);
      end
    end

    if (in_ready_int) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op;
        s1_a_d  = A;
        s1_b_d  = B;
      end
    end

    if (out_valid_q && out_ready) begin
      txn_count_d = txn_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      txn_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign in_ready  = in_ready_int;
  assign out_valid = out_valid_q;
  assign X         = x_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (DATA_WIDTH=4, CNT_WIDTH=4): directed cases, stall/reset
// scenarios and random traffic scored against an arithmetic reference queue.
module tb_addsub_pipe;

  localparam int DW = 4;
  localparam int CW = 4;
  localparam int RW = DW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          op;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   X;
  logic          borrow;
  logic          zero;
  logic [CW-1:0] txn_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0] exp_q[$];
  int            cnt_m = 0;
  int            n_out = 0;
  logic          prev_rst = 1'b0;
  logic          hold = 1'b0;
  logic [RW-1:0] held;

  addsub_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .X(X),
    .borrow(borrow), .zero(zero), .txn_count(txn_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain arithmetic from the operation definition, packed {X, borrow, zero}.
  function automatic logic [RW-1:0] model(input logic o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int   r;
    int   m;
    logic bw;
    logic [DW:0] xr;
    m  = 1 << (DW + 1);
    bw = o && (int'(a) < int'(b));
    r  = o ? ((int'(a) - int'(b) + m) % m) : (int'(a) + int'(b));
`ifdef ADDSUB_SAT_EN
    if (bw) r = 0;
`endif
    xr = r[DW:0];
    return {xr, bw, (r == 0)};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (prev_rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_x", X, 0);
      check("rst_borrow", borrow, 0);
      check("rst_zero", zero, 0);
      check("rst_txn", txn_count, 0);
    end
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      exp_q.delete();
      cnt_m = 0;
      hold  = 1'b0;
    end else begin
      check("in_ready", in_ready, (exp_q.size() < 2 || out_ready) ? 1 : 0);
      check("txn_count", txn_count, cnt_m);
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {X, borrow, zero}, held);
      end
      if (out_valid) begin
        check("out_expected", (exp_q.size() != 0) ? 1 : 0, 1);
        if (exp_q.size() != 0) check("result", {X, borrow, zero}, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        cnt_m = (cnt_m + 1) % (1 << CW);
        n_out++;
      end
      hold = out_valid && !out_ready;
      held = {X, borrow, zero};
      if (in_valid && in_ready) exp_q.push_back(model(op, A, B));
    end
    prev_rst = rst;
  end

  // Driver tasks
  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_operands();
    op = 1'($urandom_range(0, 1));
    A  = DW'($urandom_range(0, (1 << DW) - 1));
    B  = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  task automatic directed(input logic o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int ex, input int eb, input int ez);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; A = a; B = b; out_ready = 1'b1;
    @(negedge clk);
    check("dir_accept", in_ready, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check("dir_latency", n, 2);
    check("dir_x", X, ex);
    check("dir_borrow", borrow, eb);
    check("dir_zero", zero, ez);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    int sent;
    int vcount;
    int out_before;
    logic saw_drop;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_in_ready", in_ready, 1);

    // Directed arithmetic cases and boundaries
    directed(1'b0, 4'd15, 4'd15, 30, 0, 0);
`ifdef ADDSUB_SAT_EN
    directed(1'b1, 4'd3, 4'd5, 0, 1, 1);
`else
    directed(1'b1, 4'd3, 4'd5, 30, 1, 0);
`endif
    directed(1'b1, 4'd7, 4'd7, 0, 0, 1);
    directed(1'b0, 4'd0, 4'd0, 0, 0, 1);
    directed(1'b1, 4'd15, 4'd0, 15, 0, 0);
    directed(1'b0, 4'd9, 4'd8, 17, 0, 0);

    // Eight back-to-back beats with out_ready low for cycles 3-5
    do_reset(1);
    sent = 0; saw_drop = 1'b0; out_before = n_out;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      if (sent < 8) rand_operands();
      @(negedge clk);
      if (in_valid && !in_ready) saw_drop = 1'b1;
      if (in_valid && in_ready) sent++;
    end
    drain();
    check("stream_sent", sent, 8);
    check("stream_ready_drop", saw_drop, 1);
    check("stream_outputs", n_out - out_before, 8);
    check("stream_txn", txn_count, 8);

    // Reset with two beats in flight
    do_reset(1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; rand_operands();
    @(posedge clk); #1;
    rand_operands();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("flight_full_ready", in_ready, 0);
    check("flight_out_valid", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_txn", txn_count, 0);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("flush_no_beats", vcount, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_operands();
    end
    drain();

    // Counter wrap: 17 transfers through a 4-bit counter
    do_reset(1);
    sent = 0;
    for (int cyc = 0; cyc < 40 && sent < 17; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; rand_operands();
      @(negedge clk);
      if (in_ready) sent++;
    end
    drain();
    check("wrap_sent", sent, 17);
    check("wrap_txn", txn_count, 1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
